// File: rtl/instr_encoder_pkg.sv
// Shared instruction-set constants: request classes, R-type function selects,
// opcodes and funct codes, used by the encoder and the control unit decoder.
package instr_encoder_pkg;

    typedef enum logic [2:0] {
        CLS_R    = 3'd0,
        CLS_LW   = 3'd1,
        CLS_SW   = 3'd2,
        CLS_BEQ  = 3'd3,
        CLS_JUMP = 3'd4,
        CLS_ADDI = 3'd5
    } req_class_e;

    typedef enum logic [2:0] {
        FN_ADD = 3'd0,
        FN_SUB = 3'd1,
        FN_AND = 3'd2,
        FN_OR  = 3'd3,
        FN_MUL = 3'd4
    } func_sel_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_JUMP = 6'b001000;
    localparam logic [5:0] OP_ADDI = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_MUL = 6'b011000;

    localparam int FIFO_WIDTH = 32;
    localparam int FIFO_DEPTH = 4;

    // Maps an R-type function select to its funct field; legal=0 for 5..7.
    function automatic logic [6:0] r_funct(input logic [2:0] sel);
        logic [6:0] res;
        res = {1'b1, FUNCT_ADD};
        case (func_sel_e'(sel))
            FN_ADD:  res = {1'b1, FUNCT_ADD};
            FN_SUB:  res = {1'b1, FUNCT_SUB};
            FN_AND:  res = {1'b1, FUNCT_AND};
            FN_OR:   res = {1'b1, FUNCT_OR};
            FN_MUL:  res = {1'b1, FUNCT_MUL};
            default: res = {1'b0, 6'b000000};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/instr_encoder_fifo.sv
// Show-ahead FIFO with registered storage; the head entry is driven straight
// from storage and forced to zero while empty.
module instr_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is never cleared; emptiness masks stale data on the read port.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/instr_encoder.sv
// Encodes field requests into 32-bit instruction words combinationally and
// queues them in a 4-entry show-ahead FIFO; illegal requests pulse err.
module instr_encoder
    import instr_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_class,
    input  logic [2:0]  func_sel,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic        err,
    output logic [2:0]  count
);

    logic        w_legal;
    logic [31:0] w_word;
    logic [6:0]  w_funct;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic        r_err;

    assign w_funct = r_funct(func_sel);

    always_comb begin
        w_legal = 1'b1;
        w_word  = '0;
        case (req_class_e'(req_class))
            CLS_R: begin
                w_legal = w_funct[6];
                w_word  = {OP_R, rs, rt, rd, 5'b00000, w_funct[5:0]};
            end
            CLS_LW:   w_word = {OP_LW, rs, rt, imm};
            CLS_SW:   w_word = {OP_SW, rs, rt, imm};
            CLS_BEQ:  w_word = {OP_BEQ, rs, rt, imm};
            CLS_JUMP: w_word = {OP_JUMP, target};
            CLS_ADDI: w_word = {OP_ADDI, rs, rt, imm};
            default:  w_legal = 1'b0;
        endcase
    end

    // No pop bypass: a full FIFO refuses requests even while it is being drained.
    assign req_ready   = !w_full;
    assign w_accept    = req_valid && req_ready;
    assign w_push      = w_accept && w_legal;
    assign instr_valid = !w_empty;
    assign w_pop       = instr_valid && instr_ready;

    instr_fifo #(
        .WIDTH(FIFO_WIDTH),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_word),
        .i_pop   (w_pop),
        .o_rdata (instr),
        .o_count (count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_err <= 1'b0;
        else     r_err <= w_accept && !w_legal;
    end

    assign err = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a queue-based model checked every cycle,
// plus literal expectations for the reference encodings.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_class = '0;
    logic [2:0]  func_sel = '0;
    logic [4:0]  rs = '0, rt = '0, rd = '0;
    logic [15:0] imm = '0;
    logic [25:0] target = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic        err;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail = 0;
    bit done = 1'b0;

    logic [31:0] mq[$];
    logic        m_err = 1'b0;

    always #5 clk = ~clk;

    instr_encoder dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_class   (req_class),
        .func_sel    (func_sel),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .imm         (imm),
        .target      (target),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .err         (err),
        .count       (count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Returns {legal, word}, built from field positions with plain arithmetic.
    function automatic logic [32:0] model_enc(input logic [2:0] c, input logic [2:0] f,
                                              input logic [4:0] a, input logic [4:0] b,
                                              input logic [4:0] d, input logic [15:0] im,
                                              input logic [25:0] tg);
        int unsigned op[6] = '{0, 35, 43, 4, 8, 2};
        int unsigned fn[5] = '{32, 34, 36, 37, 24};
        int unsigned w;
        if (c > 5 || (c == 0 && f > 4)) return {1'b0, 32'h0};
        if (c == 4) begin
            w = op[c] * (2**26) + tg;
        end else begin
            w = op[c] * (2**26) + a * (2**21) + b * (2**16);
            if (c == 0) w = w + d * (2**11) + fn[f];
            else        w = w + im;
        end
        return {1'b1, w};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_err = 1'b0;
        end else begin
            bit acc;
            bit pop;
            logic [32:0] e;
            acc = req_valid && (mq.size() < 4);
            pop = (mq.size() != 0) && instr_ready;
            e = model_enc(req_class, func_sel, rs, rt, rd, imm, target);
            if (pop) void'(mq.pop_front());
            if (acc && e[32]) mq.push_back(e[31:0]);
            m_err = acc && !e[32];
        end
    end

    always @(negedge clk) begin
        if (!done) begin
            chk("count", {29'b0, count}, 32'(mq.size()));
            chk("instr_valid", {31'b0, instr_valid}, {31'b0, mq.size() != 0});
            chk("req_ready", {31'b0, req_ready}, {31'b0, mq.size() < 4});
            chk("err", {31'b0, err}, {31'b0, m_err});
            chk("instr", instr, (mq.size() != 0) ? mq[0] : 32'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] c, input logic [2:0] f, input logic [4:0] a,
                        input logic [4:0] b, input logic [4:0] d, input logic [15:0] im,
                        input logic [25:0] tg);
        bit ok;
        ok = 1'b0;
        req_class = c; func_sel = f; rs = a; rt = b; rd = d; imm = im; target = tg;
        req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ok = req_ready;
            tick();
            if (ok) break;
        end
        req_valid = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL send_timeout: request class %0d not accepted within 20 cycles", c);
        end
        $display("req class=%0d func=%0d -> count=%0d err=%0b instr=%h", c, f, count, err, instr);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_count", {29'b0, count}, 32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_instr", instr, 32'h0);
        chk("rst_err", {31'b0, err}, 32'd0);
        rst = 1'b0;
        tick();

        // R ADD
        send(3'd0, 3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        chk("radd_instr", instr, 32'h00221820);
        chk("radd_valid", {31'b0, instr_valid}, 32'd1);
        chk("radd_count", {29'b0, count}, 32'd1);
        instr_ready = 1'b1; tick(); instr_ready = 1'b0;

        // LW then SW with consumer always ready
        instr_ready = 1'b1;
        send(3'd1, 3'd0, 5'd4, 5'd5, 5'd0, 16'h0010, 26'h0);
        chk("lw_instr", instr, 32'h8C850010);
        send(3'd2, 3'd0, 5'd4, 5'd5, 5'd0, 16'hFFFC, 26'h0);
        chk("sw_instr", instr, 32'hAC85FFFC);
        chk("sw_count", {29'b0, count}, 32'd1);
        tick();
        instr_ready = 1'b0;

        // BEQ then JUMP
        send(3'd3, 3'd0, 5'd1, 5'd2, 5'd0, 16'd3, 26'h0);
        send(3'd4, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h40);
        chk("beq_instr", instr, 32'h10220003);
        chk("beq_count", {29'b0, count}, 32'd2);
        instr_ready = 1'b1; tick();
        chk("jump_instr", instr, 32'h20000040);
        tick(); instr_ready = 1'b0;

        // Fill to 4, fifth held until one pop
        send(3'd5, 3'd0, 5'd1, 5'd2, 5'd0, 16'd1, 26'h0);
        send(3'd0, 3'd1, 5'd3, 5'd4, 5'd5, 16'h0, 26'h0);
        send(3'd0, 3'd2, 5'd6, 5'd7, 5'd8, 16'h0, 26'h0);
        send(3'd0, 3'd3, 5'd9, 5'd10, 5'd11, 16'h0, 26'h0);
        req_class = 3'd0; func_sel = 3'd4; rs = 5'd7; rt = 5'd8; rd = 5'd9;
        req_valid = 1'b1;
        tick(); tick();
        chk("full_count", {29'b0, count}, 32'd4);
        chk("full_ready", {31'b0, req_ready}, 32'd0);
        chk("full_head", instr, 32'h08220001);
        instr_ready = 1'b1; tick(); instr_ready = 1'b0;
        chk("after_pop_count", {29'b0, count}, 32'd3);
        tick();
        req_valid = 1'b0;
        chk("fifth_count", {29'b0, count}, 32'd4);
        instr_ready = 1'b1;
        tick(); tick(); tick();
        chk("mul_instr", instr, 32'h00E84818);
        tick();
        instr_ready = 1'b0;

        // Push and pop together at count==1
        send(3'd5, 3'd0, 5'd1, 5'd2, 5'd0, 16'd5, 26'h0);
        instr_ready = 1'b1;
        send(3'd5, 3'd0, 5'd1, 5'd2, 5'd0, 16'd6, 26'h0);
        chk("pp_count", {29'b0, count}, 32'd1);
        chk("pp_instr", instr, 32'h08220006);
        tick();
        instr_ready = 1'b0;

        // Illegal requests
        send(3'd7, 3'd0, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1);
        chk("cls7_err", {31'b0, err}, 32'd1);
        chk("cls7_count", {29'b0, count}, 32'd0);
        tick();
        chk("cls7_err_end", {31'b0, err}, 32'd0);
        send(3'd0, 3'd6, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1);
        chk("fs6_err", {31'b0, err}, 32'd1);
        tick();
        chk("fs6_err_end", {31'b0, err}, 32'd0);

        // Illegal request while full is refused
        for (int i = 0; i < 4; i++)
            send(3'd1, 3'd0, 5'(i), 5'(i + 1), 5'd0, 16'(i * 3), 26'h0);
        req_class = 3'd6; req_valid = 1'b1;
        tick(); tick();
        req_valid = 1'b0;
        chk("full_illegal_err", {31'b0, err}, 32'd0);
        chk("full_illegal_count", {29'b0, count}, 32'd4);

        // Three queued words plus an in-flight err, then async reset mid-cycle
        instr_ready = 1'b1; tick(); instr_ready = 1'b0;
        send(3'd6, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        chk("pre_rst_count", {29'b0, count}, 32'd3);
        chk("pre_rst_err", {31'b0, err}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_count", {29'b0, count}, 32'd0);
        chk("async_rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("async_rst_instr", instr, 32'h0);
        chk("async_rst_err", {31'b0, err}, 32'd0);
        chk("async_rst_ready", {31'b0, req_ready}, 32'd1);
        tick(); tick();
        rst = 1'b0;

        // Popping an empty FIFO has no effect
        instr_ready = 1'b1;
        tick(); tick();
        chk("empty_pop_count", {29'b0, count}, 32'd0);
        instr_ready = 1'b0;
        send(3'd4, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FFFFFF);
        chk("jump_max", instr, 32'h23FFFFFF);
        tick();

        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Port list SHALL be as follows (clock and reset first):
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  field request present
- req_ready  out  1  block can accept a request
- req_class  in  3  0=R, 1=LW, 2=SW, 3=BEQ, 4=JUMP, 5=ADDI, 6..7 illegal
- func_sel  in  3  R only: 0=ADD, 1=SUB, 2=AND, 3=OR, 4=MUL, 5..7 illegal
- rs, rt, rd  in  5 each  register fields
- imm  in  16  immediate / offset
- target  in  26  jump target
- instr_valid  out  1  head word available
- instr_ready  in  1  consumer takes head word
- instr  out  32  encoded word at FIFO head
- err  out  1  one-cycle pulse on illegal request
- count  out  3  FIFO occupancy, 0..4

Function
REQ-003 A request SHALL be accepted on a rising edge where req_valid && req_ready.
REQ-004 req_ready SHALL be 1 when count<4 and 0 when count==4, with no same-cycle pop bypass.
REQ-005 Opcodes SHALL be: R=000000, LW=100011, SW=101011, BEQ=000100, JUMP=001000, ADDI=000010.
REQ-006 R-type words SHALL be {000000, rs, rt, rd, 00000, funct}, with funct ADD=100000, SUB=100010, AND=100100, OR=100101, MUL=011000.
REQ-007 LW, SW, BEQ and ADDI words SHALL be {opcode, rs, rt, imm}.
REQ-008 JUMP words SHALL be {001000, target}.
REQ-009 An accepted legal request SHALL be written to a 4-entry FIFO at the accepting edge, so instr_valid rises on the next cycle (latency 1).
REQ-010 An accepted illegal request (class 6..7, or class R with func_sel 5..7) SHALL complete its handshake, SHALL NOT be written, and SHALL pulse err high for exactly the following cycle.
REQ-011 instr_valid SHALL equal (count!=0), and instr SHALL present the head entry show-ahead, driven directly from storage.
REQ-012 A pop SHALL occur on a rising edge where instr_valid && instr_ready; instr SHALL hold stable while instr_valid && !instr_ready.
REQ-013 A simultaneous push and pop SHALL leave count unchanged and preserve order, including at count==1.
REQ-014 Read and write pointers SHALL be 2 bits and wrap 3->0; count SHALL never exceed 4 or underflow below 0.
REQ-015 instr_ready while empty SHALL have no effect; an illegal request while full SHALL NOT be accepted (req_ready=0).

Reset
REQ-016 While rst=1, the block SHALL force: count=0, pointers=0, instr_valid=0, err=0, req_ready=1.
REQ-017 instr SHALL read 32'h0 after reset.
REQ-018 Reset asserted mid-operation SHALL discard all queued words and any in-flight err pulse immediately.
REQ-019 Storage contents SHALL NOT need clearing beyond making instr read 0 when empty.

Structure
REQ-020 Opcode, funct and req_class constants SHALL reside in a shared package, also used by the control unit decoder.
REQ-021 The FIFO SHALL be a separate sub-module instr_fifo (parameterized width=32, depth=4), instantiated once.
REQ-022 Encoding logic SHALL be combinational ahead of the FIFO write port, with no further pipeline stage.

Verification
REQ-023 R ADD, rs=1, rt=2, rd=3 -> next cycle instr=0x00221820, instr_valid=1, count=1.
REQ-024 LW rs=4, rt=5, imm=0x0010, then SW rs=4, rt=5, imm=0xFFFC, with instr_ready=1 -> pops 0x8C850010 then 0xAC85FFFC, in order.
REQ-025 BEQ rs=1, rt=2, imm=3, then JUMP target=0x40 -> 0x10220003, then 0x20000040.
REQ-026 Five back-to-back legal requests with instr_ready=0 -> count=4, req_ready=0, fifth request held; one pop -> fifth request accepted, order intact.
REQ-027 req_class=7 -> err=1 for one cycle, count unchanged; R with func_sel=6 -> same behaviour.
REQ-028 Fill with 3 words, assert rst mid-cycle -> count=0, instr_valid=0, instr=0 immediately, without waiting for a clock edge.
